// File: rtl/pipe_pkg.sv
// Package: pipe_pkg
// Shared types and constants for the pipe_skid_buffer slice.
//   skid_state_e : occupancy-encoded FSM state of the skid buffer
//   OCC_W        : width of the occupancy output (holds 0, 1 or 2)
package pipe_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } skid_state_e;

  localparam int OCC_W = 2;

endpackage : pipe_pkg

// File: rtl/pipe_if.sv
// Interface: pipe_if
// Bundles every port of pipe_skid_buffer so benches can pass a single
// handle around instead of ten loose signals.
//   clk                : single rising-edge clock (interface port)
//   rst                : synchronous active-high reset
//   in_data/in_valid   : upstream beat
//   in_ready           : stage can accept
//   out_data/out_valid : downstream beat
//   out_ready          : downstream accepts
//   occupancy          : beats held (0..2)
//   beat_cnt           : wrapping count of output fires
interface pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic clk
);
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] beat_cnt;
endinterface : pipe_if

// File: rtl/pipe_skid_buffer.sv
// Module: pipe_skid_buffer
// Registered valid/ready pipeline stage with a one-entry skid register.
// in_ready comes straight from a flop, so there is no combinational path
// from out_ready back to in_ready, yet the stage still streams one beat per
// cycle. A wrapping counter tracks completed output beats.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_data    in   WIDTH  upstream data
//   in_valid   in   1      upstream data valid
//   in_ready   out  1      stage can accept (registered)
//   out_data   out  WIDTH  main register contents
//   out_valid  out  1      main register holds a beat
//   out_ready  in   1      downstream accepts
//   occupancy  out  OCC_W  beats held: 0, 1 or 2
//   beat_cnt   out  CNT_W  output fires since reset, modulo 2^CNT_W
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] beat_cnt
);

  skid_state_e      state_reg, state_next;
  logic [WIDTH-1:0] main_reg,  main_next;
  logic [WIDTH-1:0] skid_reg,  skid_next;
  logic             in_ready_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic accept;
  logic fire;

  assign accept = in_valid & in_ready_reg;
  assign fire   = out_valid & out_ready;

  // Next-state and datapath. The skid register is only written when the
  // main register is occupied and stalled, so it never needs to feed the
  // output directly; it is drained into main on the next fire.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      S_EMPTY: begin
        if (accept) begin
          state_next = S_BUSY;
          main_next  = in_data;
        end
      end
      S_BUSY: begin
        if (accept && fire) begin
          main_next = in_data;
        end else if (accept) begin
          state_next = S_FULL;
          skid_next  = in_data;
        end else if (fire) begin
          state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so accept cannot be true.
        if (fire) begin
          state_next = S_BUSY;
          main_next  = skid_reg;
        end
      end
      default: begin
        state_next = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      // Look ahead one state so ready drops in the same cycle the skid fills.
      in_ready_reg <= (state_next != S_FULL);
      cnt_reg      <= cnt_reg + CNT_W'(fire);
    end
  end

  always_comb begin
    occupancy = '0;
    case (state_reg)
      S_EMPTY: occupancy = OCC_W'(0);
      S_BUSY:  occupancy = OCC_W'(1);
      S_FULL:  occupancy = OCC_W'(2);
      default: occupancy = OCC_W'(0);
    endcase
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != S_EMPTY);
  assign out_data  = main_reg;
  assign beat_cnt  = cnt_reg;

endmodule : pipe_skid_buffer

// File: tb/tb_pipe_skid_buffer.sv
// Testbench: tb_pipe_skid_buffer
// Directed stimulus drives a 16-bit-counter instance through the interface
// and a 4-bit-counter instance from the same inputs. A negedge monitor keeps
// a scoreboard queue of accepted beats and checks every output fire.
module tb_pipe_skid_buffer;

  logic clk;
  int   cyc;
  int   n_pass;
  int   n_total;
  int   model_cnt;
  bit   cnt_chk;
  logic [7:0] exp_q[$];

  pipe_if #(.WIDTH(8), .CNT_W(16)) bus (.clk(clk));

  logic       in_ready4;
  logic [7:0] out_data4;
  logic       out_valid4;
  logic [1:0] occupancy4;
  logic [3:0] cnt4;

  pipe_skid_buffer #(.WIDTH(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (bus.rst),
    .in_data   (bus.in_data),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .occupancy (bus.occupancy),
    .beat_cnt  (bus.beat_cnt)
  );

  pipe_skid_buffer #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (bus.rst),
    .in_data   (bus.in_data),
    .in_valid  (bus.in_valid),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (bus.out_ready),
    .occupancy (occupancy4),
    .beat_cnt  (cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: sampled on the falling edge, i.e. the values the
  // next rising edge will act on.
  always @(negedge clk) begin
    logic [7:0] exp_d;
    if (cnt_chk) begin
      check("beat_cnt", 32'(bus.beat_cnt), 32'(model_cnt[15:0]));
      check("beat_cnt4", 32'(cnt4), 32'(model_cnt[3:0]));
      cnt_chk = 1'b0;
    end
    if (bus.rst) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL out_unexpected: got beat %0h expected none", bus.out_data);
        end else begin
          exp_d = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(exp_d));
          check("out_data4", 32'(out_data4), 32'(exp_d));
        end
        model_cnt++;
        cnt_chk = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
    end
  end

  // Present one beat and hold it until it is accepted; returns 1 time unit
  // after the accepting edge with in_valid still high.
  task automatic send(input logic [7:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_total++;
    $display("FAIL send_timeout: got in_ready=0 for 20 cycles, required 1 (data %0h)", d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c0;
    n_pass = 0; n_total = 0; model_cnt = 0; cnt_chk = 1'b0; cyc = 0;
    bus.rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.out_ready = 1'b1;

    // Reset with a beat offered: nothing may be accepted.
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_occupancy", 32'(bus.occupancy), 32'd0);
    check("rst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_after_edge", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Streaming 30 beats back-to-back.
    bus.out_ready = 1'b1;
    c0 = cyc;
    for (int i = 1; i <= 30; i++) begin
      send(8'(i));
      check("stream_occ", 32'(bus.occupancy), 32'd1);
    end
    bus.in_valid = 1'b0;
    check("stream_cycles", 32'(cyc - c0), 32'd30);
    idle(2);
    check("stream_beat_cnt", 32'(bus.beat_cnt), 32'd30);
    check("stream_drained", 32'(bus.occupancy), 32'd0);

    // Backpressure fills the skid register.
    bus.out_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    bus.in_valid = 1'b0;
    check("bp_occ", 32'(bus.occupancy), 32'd2);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_out_data", 32'(bus.out_data), 32'h11);
    idle(3);
    check("bp_hold_data", 32'(bus.out_data), 32'h11);
    check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    idle(3);
    check("bp_drained", 32'(bus.occupancy), 32'd0);
    check("bp_beat_cnt", 32'(bus.beat_cnt), 32'd32);

    // Simultaneous accept and fire in S_BUSY.
    bus.out_ready = 1'b0;
    send(8'h33);
    bus.in_valid = 1'b0;
    check("sim_hold33", 32'(bus.out_data), 32'h33);
    bus.out_ready = 1'b1;
    send(8'h44);
    bus.in_valid = 1'b0;
    check("sim_out_data", 32'(bus.out_data), 32'h44);
    check("sim_occ", 32'(bus.occupancy), 32'd1);
    idle(2);
    check("sim_beat_cnt", 32'(bus.beat_cnt), 32'd34);

    // Reset while full: held beats are discarded.
    bus.out_ready = 1'b0;
    send(8'h55);
    send(8'h66);
    bus.in_valid = 1'b0;
    check("mr_full", 32'(bus.occupancy), 32'd2);
    bus.rst = 1'b1;
    @(posedge clk);
    #1;
    bus.rst = 1'b0;
    check("mr_occ", 32'(bus.occupancy), 32'd0);
    check("mr_out_valid", 32'(bus.out_valid), 32'd0);
    check("mr_beat_cnt", 32'(bus.beat_cnt), 32'd0);
    bus.out_ready = 1'b1;
    idle(4);
    check("mr_still_empty", 32'(bus.out_valid), 32'd0);
    check("mr_cnt_still0", 32'(bus.beat_cnt), 32'd0);

    // 4-bit counter wrap over 17 fires; fires lag accepts by one cycle.
    for (int i = 1; i <= 17; i++) begin
      send(8'(8'h80 + i));
      if (i == 16) check("wrap_after15", 32'(cnt4), 32'hF);
      if (i == 17) check("wrap_after16", 32'(cnt4), 32'h0);
    end
    bus.in_valid = 1'b0;
    idle(2);
    check("wrap_after17", 32'(cnt4), 32'h1);
    check("wide_after17", 32'(bus.beat_cnt), 32'd17);

    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pipe_skid_buffer
